// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : MEM-stage data-memory access controller (valid/ready request,
//            response wait with timeout, store steering, load extension).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        im_stall,
    output logic        dm_req_valid,
    input  logic        dm_req_ready,
    output logic        dm_req_write,
    output logic [31:0] dm_req_addr,
    output logic [3:0]  dm_req_wstrb,
    output logic [31:0] dm_req_wdata,
    input  logic        dm_resp_valid,
    input  logic [31:0] dm_resp_rdata,
    output logic        dm_stall,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int         c_CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit         c_TMO_EN   = (TIMEOUT_CYCLES > 0);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_off;
    logic [2:0]           r_f3;
    logic [c_CNT_W-1:0]   r_tmo;

    logic                 w_access;
    logic                 w_go;
    logic                 w_tmo_hit;
    logic [3:0]           w_wstrb;
    logic [31:0]          w_wdata;
    logic [31:0]          w_shift;
    logic [31:0]          w_load;

    // Decode access legality from the live MEM-stage inputs
    always_comb begin
        w_access = mem_read | mem_write;
        misalign = 1'b0;
        if (w_access) begin
            case (funct3)
                3'b001, 3'b101: misalign = addr[0];
                3'b010:         misalign = (addr[1:0] != 2'b00);
                3'b011, 3'b110, 3'b111: misalign = 1'b1;
                default:        misalign = 1'b0;
            endcase
        end
        w_go = w_access & ~misalign;
    end

    // Store byte-lane steering; loads carry no byte enables
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{wdata[15:0]}};
            end
            default: w_wstrb = 4'b1111;
        endcase
        if (!mem_write) begin
            w_wstrb = 4'b0000;
        end
    end

    // Aligned accesses only, so shifting by the byte offset also aligns halves
    always_comb begin
        w_shift = dm_resp_rdata >> {r_off, 3'b000};
        case (r_f3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load = {24'h0, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_load = {16'h0, w_shift[15:0]};
            default: w_load = dm_resp_rdata;
        endcase
    end

    assign w_tmo_hit = c_TMO_EN && (r_tmo == c_TMO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_go)          w_next = S_REQ;
            S_REQ:  if (dm_req_ready)  w_next = S_WAIT;
            S_WAIT: if (dm_resp_valid || w_tmo_hit) w_next = S_DONE;
            S_DONE: if (!im_stall)     w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    assign dm_req_valid = (r_state == S_REQ);
    assign dm_stall     = ((r_state == S_IDLE) & w_go) | (r_state == S_REQ) |
                          (r_state == S_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_off        <= 2'b00;
            r_f3         <= 3'b000;
            r_tmo        <= '0;
            dm_req_write <= 1'b0;
            dm_req_addr  <= 32'h0;
            dm_req_wstrb <= 4'h0;
            dm_req_wdata <= 32'h0;
            load_data    <= 32'h0;
            bus_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            bus_err <= 1'b0;
            if ((r_state == S_IDLE) && w_go) begin
                r_off        <= addr[1:0];
                r_f3         <= funct3;
                dm_req_write <= mem_write;
                dm_req_addr  <= {addr[31:2], 2'b00};
                dm_req_wstrb <= w_wstrb;
                dm_req_wdata <= w_wdata;
            end
            if (r_state == S_WAIT) begin
                if (dm_resp_valid) begin
                    if (!dm_req_write) begin
                        load_data <= w_load;
                    end
                end else if (w_tmo_hit) begin
                    bus_err <= 1'b1;
                    if (!dm_req_write) begin
                        load_data <= 32'h0;
                    end
                end
            end
            // Counter runs only while remaining in WAIT; any exit clears it
            if ((r_state == S_WAIT) && (w_next == S_WAIT)) begin
                if (r_tmo != '1) begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Brief    : Directed self-checking bench for dmem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        im_stall;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic        dm_req_write;
    logic [31:0] dm_req_addr;
    logic [3:0]  dm_req_wstrb;
    logic [31:0] dm_req_wdata;
    logic        dm_resp_valid;
    logic [31:0] dm_resp_rdata;
    logic        dm_stall;
    logic [31:0] load_data;
    logic        misalign;
    logic        bus_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .im_stall      (im_stall),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_req_write  (dm_req_write),
        .dm_req_addr   (dm_req_addr),
        .dm_req_wstrb  (dm_req_wstrb),
        .dm_req_wdata  (dm_req_wdata),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_rdata (dm_resp_rdata),
        .dm_stall      (dm_stall),
        .load_data     (load_data),
        .misalign      (misalign),
        .bus_err       (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one access to completion; memory answers resp immediately once
    // waiting, ready after dly refused REQ cycles. Returns what it observed.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdata, input int dly,
                              output int stalls, output int req_n, output logic stable,
                              output logic [3:0] strb, output logic [31:0] raddr,
                              output logic [31:0] rwd, output logic rwr,
                              output logic [31:0] ld);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        dm_req_ready = 1'b0; dm_resp_valid = 1'b1; dm_resp_rdata = rdata;
        stalls = 0; req_n = 0; stable = 1'b1;
        strb = 4'h0; raddr = 32'h0; rwd = 32'h0; rwr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!dm_stall) break;
            stalls++;
            if (dm_req_valid) begin
                if (req_n == 0) begin
                    strb = dm_req_wstrb; raddr = dm_req_addr;
                    rwd = dm_req_wdata; rwr = dm_req_write;
                end else if (strb !== dm_req_wstrb || raddr !== dm_req_addr ||
                             rwd !== dm_req_wdata || rwr !== dm_req_write) begin
                    stable = 1'b0;
                end
                req_n++;
                dm_req_ready = (req_n > dly);
            end
            @(posedge clk);
        end
        ld = load_data;
        mem_read = 1'b0; mem_write = 1'b0;
        dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b010;
        addr = 32'h0; wdata = 32'h0; im_stall = 1'b0; dm_req_ready = 1'b0;
        dm_resp_valid = 1'b0; dm_resp_rdata = 32'h0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (dm_req_valid !== 1'b0 || dm_stall !== 1'b0 || bus_err !== 1'b0) begin
            $display("FAIL reset_ctrl: valid/stall/err=%b%b%b required 000",
                     dm_req_valid, dm_stall, bus_err);
        end else n_pass++;
        n_total++;
        if (dm_req_write !== 1'b0 || dm_req_addr !== 32'h0 || dm_req_wstrb !== 4'h0 ||
            dm_req_wdata !== 32'h0 || load_data !== 32'h0) begin
            $display("FAIL reset_regs: wr=%b addr=%h strb=%h wd=%h ld=%h required all zero",
                     dm_req_write, dm_req_addr, dm_req_wstrb, dm_req_wdata, load_data);
        end else n_pass++;
        tick();
    endtask

    task automatic test_lw();
        int st, rq; logic sb; logic [3:0] sk; logic [31:0] ra, rw, ld; logic wr;
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0,
                   st, rq, sb, sk, ra, rw, wr, ld);
        n_total++;
        if (st !== 3) $display("FAIL lw_stall: got %0d cycles required 3", st);
        else n_pass++;
        n_total++;
        if (ld !== 32'hDEAD_BEEF) $display("FAIL lw_data: got %h required deadbeef", ld);
        else n_pass++;
        n_total++;
        if (ra !== 32'h0000_0100 || sk !== 4'b0000 || wr !== 1'b0 || rq !== 1)
            $display("FAIL lw_req: addr=%h strb=%b wr=%b reqcyc=%0d required 00000100 0000 0 1",
                     ra, sk, wr, rq);
        else n_pass++;
    endtask

    task automatic test_load_ext();
        int st, rq; logic sb; logic [3:0] sk; logic [31:0] ra, rw, ld; logic wr;
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
        logic [31:0] as  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF,
                                 32'hFFFF_80FF, 32'h0000_0000};
        for (int k = 0; k < 5; k++) begin
            run_access(1'b1, 1'b0, f3s[k], as[k], 32'h0, 32'h80FF_0000, 0,
                       st, rq, sb, sk, ra, rw, wr, ld);
            n_total++;
            if (ld !== exp[k] || ra !== 32'h100)
                $display("FAIL load_ext[%0d]: data=%h addr=%h required %h 00000100",
                         k, ld, ra, exp[k]);
            else n_pass++;
        end
    endtask

    task automatic test_store();
        int st, rq; logic sb; logic [3:0] sk; logic [31:0] ra, rw, ld; logic wr;
        logic [31:0] ld_before;
        ld_before = load_data;
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h1111_1111, 4,
                   st, rq, sb, sk, ra, rw, wr, ld);
        n_total++;
        if (sk !== 4'b0010 || rw !== 32'hA5A5_A5A5 || ra !== 32'h200 || wr !== 1'b1)
            $display("FAIL sb_fields: strb=%b wd=%h addr=%h wr=%b required 0010 a5a5a5a5 00000200 1",
                     sk, rw, ra, wr);
        else n_pass++;
        n_total++;
        if (sb !== 1'b1 || rq !== 5 || st !== 7)
            $display("FAIL sb_hold: stable=%b reqcyc=%0d stall=%0d required 1 5 7", sb, rq, st);
        else n_pass++;
        n_total++;
        if (ld !== ld_before) $display("FAIL sb_keeps_load: got %h required %h", ld, ld_before);
        else n_pass++;
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0, 0,
                   st, rq, sb, sk, ra, rw, wr, ld);
        n_total++;
        if (sk !== 4'b1100 || rw !== 32'hBEEF_BEEF || st !== 3)
            $display("FAIL sh_fields: strb=%b wd=%h stall=%0d required 1100 beefbeef 3", sk, rw, st);
        else n_pass++;
        run_access(1'b1, 1'b1, 3'b010, 32'h0000_0204, 32'h1234_5678, 32'h0, 0,
                   st, rq, sb, sk, ra, rw, wr, ld);
        n_total++;
        if (sk !== 4'b1111 || rw !== 32'h1234_5678 || wr !== 1'b1 || ra !== 32'h204 ||
            ld !== ld_before)
            $display("FAIL sw_fields: strb=%b wd=%h wr=%b addr=%h ld=%h required 1111 12345678 1 00000204 %h",
                     sk, rw, wr, ra, ld, ld_before);
        else n_pass++;
    endtask

    task automatic test_misalign();
        logic seen_valid;
        logic seen_stall;
        mem_read = 1'b1; funct3 = 3'b001; addr = 32'h0000_0301;
        dm_req_ready = 1'b1; dm_resp_valid = 1'b1;
        seen_valid = 1'b0; seen_stall = 1'b0;
        #1;
        n_total++;
        if (misalign !== 1'b1) $display("FAIL lh_misalign: got %b required 1", misalign);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (dm_req_valid) seen_valid = 1'b1;
            if (dm_stall)     seen_stall = 1'b1;
            tick();
        end
        n_total++;
        if (seen_valid !== 1'b0 || seen_stall !== 1'b0)
            $display("FAIL lh_no_req: valid=%b stall=%b required 0 0", seen_valid, seen_stall);
        else n_pass++;
        funct3 = 3'b011; addr = 32'h0000_0300;
        #1;
        n_total++;
        if (misalign !== 1'b1 || dm_stall !== 1'b0)
            $display("FAIL f3_illegal: misalign=%b stall=%b required 1 0", misalign, dm_stall);
        else n_pass++;
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h0000_0302;
        #1;
        n_total++;
        if (misalign !== 1'b1 || dm_stall !== 1'b0)
            $display("FAIL sw_misalign: misalign=%b stall=%b required 1 0", misalign, dm_stall);
        else n_pass++;
        mem_write = 1'b0; funct3 = 3'b011;
        #1;
        n_total++;
        if (misalign !== 1'b0) $display("FAIL no_access_flag: got %b required 0", misalign);
        else n_pass++;
        dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
        tick();
    endtask

    task automatic test_im_stall();
        int st, rq; logic sb; logic [3:0] sk; logic [31:0] ra, rw, ld; logic wr;
        logic bad;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0104; im_stall = 1'b1;
        dm_req_ready = 1'b1; dm_resp_valid = 1'b1; dm_resp_rdata = 32'h1234_5678;
        tick(); tick(); tick();
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (dm_req_valid !== 1'b0 || dm_stall !== 1'b0) bad = 1'b1;
            tick();
        end
        n_total++;
        if (bad !== 1'b0) $display("FAIL done_hold: reissue or stall seen=%b required 0", bad);
        else n_pass++;
        n_total++;
        if (load_data !== 32'h1234_5678)
            $display("FAIL done_data: got %h required 12345678", load_data);
        else n_pass++;
        im_stall = 1'b0; mem_read = 1'b0; dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
        tick();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'h0, 32'h0BAD_F00D, 0,
                   st, rq, sb, sk, ra, rw, wr, ld);
        n_total++;
        if (st !== 3 || ld !== 32'h0BAD_F00D)
            $display("FAIL after_done: stall=%0d data=%h required 3 0badf00d", st, ld);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_010C;
        dm_req_ready = 1'b1; dm_resp_valid = 1'b0;
        tick();
        tick();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (bus_err) break;
        end
        n_total++;
        if (n !== 8) $display("FAIL tmo_delay: bus_err after %0d cycles required 8", n);
        else n_pass++;
        n_total++;
        if (bus_err !== 1'b1 || load_data !== 32'h0 || dm_stall !== 1'b0)
            $display("FAIL tmo_state: err=%b data=%h stall=%b required 1 00000000 0",
                     bus_err, load_data, dm_stall);
        else n_pass++;
        mem_read = 1'b0; dm_req_ready = 1'b0;
        tick();
        n_total++;
        if (bus_err !== 1'b0) $display("FAIL tmo_pulse: err=%b required 0", bus_err);
        else n_pass++;
    endtask

    task automatic test_reset_wait();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0110;
        dm_req_ready = 1'b1; dm_resp_valid = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; mem_read = 1'b0; dm_req_ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (dm_req_valid !== 1'b0 || dm_stall !== 1'b0 || dm_req_addr !== 32'h0)
            $display("FAIL rst_wait: valid=%b stall=%b addr=%h required 0 0 00000000",
                     dm_req_valid, dm_stall, dm_req_addr);
        else n_pass++;
        dm_resp_valid = 1'b1; dm_resp_rdata = 32'hCAFE_F00D;
        tick(); tick();
        n_total++;
        if (load_data !== 32'h0 || dm_stall !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL late_resp: data=%h stall=%b err=%b required 00000000 0 0",
                     load_data, dm_stall, bus_err);
        else n_pass++;
        dm_resp_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misalign();
        test_im_stall();
        test_timeout();
        test_reset_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
